key_conditioner: RTL and testbench
==================================

# key_conditioner

Front-end input stage for the lab1 random-number display. Takes the three raw active-low push-buttons (start, prev, next), synchronises and debounces each one, and emits clean single-cycle pulses to the random generator/history core. The prev and next keys auto-repeat while held; the start key never repeats.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised cycles required to accept a level change; legal values ≥ 2.
- REPEAT_DELAY, 25000000: cycles from an accepted press to the first repeat pulse; legal values ≥ 1.
- REPEAT_PERIOD, 5000000: cycles between later repeat pulses; legal values ≥ 1.
- REPEAT_MASK, 3'b110: per-key auto-repeat enable, indexed by key position.
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_key_n  in  3  raw buttons, active-low, asynchronous. Bit 0 is start, bit 1 is prev, bit 2 is next.
- o_start  out  1  single-cycle press pulse for key 0.
- o_prev  out  1  press/repeat pulse for key 1.
- o_next  out  1  press/repeat pulse for key 2.
- o_key_level  out  3  debounced pressed level per key (1 = held).

## Operation
Each key is handled by an independent channel.

- **Synchroniser:** two flops. Reset value is 1 (released). The value `pressed` is the inverse of the second flop.
- **Debounce:**
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - When `pressed` equals the stable level, the counter clears.
  - Otherwise the counter increments.
  - When it reads DEBOUNCE_CYCLES-1 on a mismatch edge, the stable level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles has no effect.
- **FSM per channel, on the debounced level:**
  - IDLE: a debounced press registers a pulse, clears the hold counter, and moves to HOLD.
  - HOLD: the hold counter increments every cycle. If it reads REPEAT_DELAY-1 and the repeat bit is set, register a pulse, clear the counter, and move to REPEAT. If the repeat bit is clear, saturate and stay in HOLD.
  - REPEAT: when the counter reads REPEAT_PERIOD-1, register a pulse and clear the counter.
  - A debounced release from HOLD or REPEAT returns to IDLE. Release produces no pulse.
- **Width rule:** hold counter width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- **Simultaneous events:** channels are fully independent. Several outputs may pulse in the same cycle. Arbitration between them belongs to the consumer.
- **Reset mid-operation:**
  - All state returns to IDLE, all counters to 0, all outputs to 0.
  - A key held through reset must re-qualify for DEBOUNCE_CYCLES and then produces a fresh press pulse.

## Timing
- **Reset values:** o_start, o_prev, o_next and o_key_level are all 0.
- **Outputs:** all outputs are registered, and each pulse lasts exactly one cycle.
- **Press latency:** define edge 0 as the first i_clk edge that samples the key low and that stays low from then on. The stable level flips and the pulse is registered at edge DEBOUNCE_CYCLES+1. The pulse is high during the following cycle.
- **Release latency:** also DEBOUNCE_CYCLES+1 edges, after which o_key_level drops.
- **Repeat pulses:** registered at edges P+REPEAT_DELAY, then every REPEAT_PERIOD edges after that, where P is the press-pulse edge.
- **Release during a repeat cycle:** if the debounced release lands on the same edge as a repeat terminal count, release wins and no pulse is emitted.

## Structure
- **Package lab1_pkg:**
  - key index constants: KEY_START=0, KEY_PREV=1, KEY_NEXT=2;
  - the channel state enum {S_IDLE, S_HOLD, S_REPEAT}.
- **Sub-module key_channel:**
  - contains one synchroniser, the debounce counter, the FSM and the hold counter;
  - takes the parameters DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD and REPEAT_EN;
  - the top instantiates it three times.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.

- **Reset:** assert i_rst_n=0 with i_key_n=3'b000 → all outputs 0. Release reset with keys still held → o_start, o_prev and o_next each pulse once, at edge 5 after the first sampling edge.
- **Clean start press:** key 0 low from edge 0 and held for 40 cycles → o_start is high only after edge 5; o_key_level[0] is 1 from edge 5; no repeats.
- **Bounce:** key 1 toggles low 3 cycles, high 1, low 2, high 1, then stays low → exactly one o_prev pulse, 5 edges after the final low begins.
- **Auto-repeat:** key 2 held from edge 0 → o_next pulses registered at edges 5, 13, 16, 19, 22. After release, no pulse, and o_key_level[2] drops 5 edges after release.
- **Simultaneous:** keys 1 and 2 pressed on the same edge → o_prev and o_next pulse in the same cycles. A 3-cycle key-0 glitch in between produces no o_start.

Source files
------------

// File: rtl/lab1_pkg.sv
// Shared constants and types for the lab1 key conditioning front end.
`default_nettype none

package lab1_pkg;

  localparam int KEY_START = 0;
  localparam int KEY_PREV  = 1;
  localparam int KEY_NEXT  = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } chan_state_e;

  // Hold counter must reach whichever of the two terminal counts is larger.
  function automatic int hold_width(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_channel.sv
// One key: two-flop synchroniser, debounce counter, press/hold/repeat FSM.
`default_nettype none

module key_channel
  import lab1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic pulse_o,
  output logic level_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = hold_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [1:0]        sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              stable_q, stable_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  chan_state_e       state_q, state_d;
  logic              pulse_q, pulse_d;
  logic              pressed, flip, press_ev, release_ev;

  assign pressed    = ~sync_q[1];
  assign flip       = (pressed != stable_q) && (db_cnt_q == DB_LAST);
  assign press_ev   = flip & ~stable_q;
  assign release_ev = flip & stable_q;

  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (pressed != stable_q) begin
      if (flip) stable_d = ~stable_q;
      else      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Release is tested first so it overrides a coincident repeat terminal count.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_ev) begin
          pulse_d = 1'b1;
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (release_ev) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else if (hold_q == DELAY_LAST) begin
          if (REPEAT_EN) begin
            pulse_d = 1'b1;
            hold_d  = '0;
            state_d = S_REPEAT;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (release_ev) begin
          hold_d  = '0;
          state_d = S_IDLE;
        end else if (hold_q == PERIOD_LAST) begin
          pulse_d = 1'b1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        hold_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      db_cnt_q <= '0;
      stable_q <= 1'b0;
      hold_q   <= '0;
      state_q  <= S_IDLE;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_ni};
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign level_o = stable_q;

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// Three independent key channels turning raw active-low buttons into clean pulses.
`default_nettype none

module key_conditioner
  import lab1_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_PERIOD   = 5000000,
  parameter logic [2:0] REPEAT_MASK     = 3'b110
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_key_n,
  output logic       o_start,
  output logic       o_prev,
  output logic       o_next,
  output logic [2:0] o_key_level
);

  logic [2:0] pulse;

  for (genvar k = 0; k < 3; k++) begin : g_chan
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[k])
    ) u_chan (
      .clk_i  (i_clk),
      .rst_ni (i_rst_n),
      .key_ni (i_key_n[k]),
      .pulse_o(pulse[k]),
      .level_o(o_key_level[k])
    );
  end

  assign o_start = pulse[KEY_START];
  assign o_prev  = pulse[KEY_PREV];
  assign o_next  = pulse[KEY_NEXT];

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: reference model predicts pulse/level events.
`default_nettype none

module tb_key_conditioner;

  localparam int         D    = 4;
  localparam int         RD   = 8;
  localparam int         RP   = 3;
  localparam logic [2:0] MASK = 3'b110;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key_n = 3'b000;
  logic       o_start, o_prev, o_next;
  logic [2:0] o_key_level;

  key_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key_n    (key_n),
    .o_start    (o_start),
    .o_prev     (o_prev),
    .o_next     (o_next),
    .o_key_level(o_key_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  pulses;
    logic [2:0]  level;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: a level flips once the last D synchronised samples all
  // disagree with it; repeats are scheduled as absolute edge numbers.
  initial begin
    logic [2:0]  hist[$];
    logic [2:0]  m_lvl, new_lvl, pul, mask;
    int unsigned next_rep[3];
    bit          flip;
    m_lvl = 3'b000;
    mask  = MASK;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        if (m_lvl != 3'b000) sb.push_back('{cyc, 3'b000, 3'b000});
        m_lvl = 3'b000;
        hist  = {};
        for (int i = 0; i < D + 2; i++) hist.push_back(3'b111);
      end else begin
        hist.push_back(key_n);
        void'(hist.pop_front());
        pul     = 3'b000;
        new_lvl = m_lvl;
        for (int k = 0; k < 3; k++) begin
          flip = 1'b1;
          for (int j = 0; j < D; j++)
            if (hist[j][k] != m_lvl[k]) flip = 1'b0;
          if (flip) begin
            new_lvl[k] = ~m_lvl[k];
            if (new_lvl[k]) begin
              pul[k]      = 1'b1;
              next_rep[k] = cyc + RD;
            end
          end else if (m_lvl[k] && mask[k] && cyc == next_rep[k]) begin
            pul[k]      = 1'b1;
            next_rep[k] = cyc + RP;
          end
        end
        if (pul != 3'b000 || new_lvl != m_lvl) sb.push_back('{cyc, pul, new_lvl});
        m_lvl = new_lvl;
      end
    end
  end

  // Monitor: any DUT pulse or level change must match the scoreboard head.
  initial begin
    logic [2:0] prev_lvl, dp;
    ev_t        e;
    prev_lvl = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      dp = {o_next, o_prev, o_start};
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        vectors++;
        if (dp !== e.pulses || o_key_level !== e.level) begin
          miscompares++;
          $display("FAIL event cyc=%0d: got pulses=%b level=%b, expected pulses=%b level=%b",
                   cyc, dp, o_key_level, e.pulses, e.level);
        end
      end else if (dp !== 3'b000 || o_key_level !== prev_lvl) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected cyc=%0d: got pulses=%b level=%b, expected pulses=000 level=%b",
                 cyc, dp, o_key_level, prev_lvl);
      end
      prev_lvl = o_key_level;
    end
  end

  task automatic play(input int k, input logic v, input int n);
    key_n[k] = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int seg_left[3];
    rst_n = 1'b0;
    key_n = 3'b000;
    repeat (3) @(negedge clk);
    vectors++;
    if ({o_next, o_prev, o_start, o_key_level} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b, expected 000000", {o_next, o_prev, o_start, o_key_level});
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    key_n = 3'b111;
    repeat (12) @(negedge clk);
    play(1, 1'b0, 3); play(1, 1'b1, 1); play(1, 1'b0, 2); play(1, 1'b1, 1);
    play(1, 1'b0, 30); play(1, 1'b1, 12);
    play(2, 1'b0, 40); play(2, 1'b1, 12);
    key_n = 3'b001;
    repeat (6) @(negedge clk);
    key_n = 3'b000;
    repeat (3) @(negedge clk);
    key_n = 3'b001;
    repeat (30) @(negedge clk);
    key_n = 3'b111;
    repeat (12) @(negedge clk);

    for (int k = 0; k < 3; k++) seg_left[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (seg_left[k] == 0) begin
          key_n[k]    = $urandom_range(0, 1) == 1;
          seg_left[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, D) : $urandom_range(D + 1, 30);
        end
        seg_left[k]--;
      end
      @(negedge clk);
    end

    key_n = 3'b111;
    repeat (30) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected events never shown, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
